// File: rtl/adc128s022_slave_model.sv
// rtl/adc128s022_slave_model.sv - ADC128S022 serial responder for loopback of the ADC master path
module adc128s022_slave_model #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12,
    parameter int LEAD_ZEROS  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  adc_sclk,
    input  logic                  adc_csn,
    input  logic                  adc_saddr,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic                  adc_sdat,
    output logic                  adc_sdat_oe,
    output logic [2:0]            cur_addr,
    output logic                  frame_done,
    output logic [DATA_W-1:0]     last_data
);
    localparam int FRAME_W = DATA_W + LEAD_ZEROS;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Stage SYNC_STAGES is the previous-sample copy used only for edge detection.
    logic [SYNC_STAGES:0]   sclk_sr, csn_sr;
    logic [SYNC_STAGES-1:0] saddr_sr;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic saddr_bit;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [1:0]           addr_sr_q, addr_sr_d;
    logic [2:0]           next_addr_q, next_addr_d, cur_addr_d;
    logic [DATA_W-1:0]    last_data_d, sel_data;
    logic                 oe_d, frame_done_d, wrapped_q, wrapped_d, load;

    assign saddr_bit = saddr_sr[SYNC_STAGES-1];
    assign adc_sdat  = shreg_q[FRAME_W-1];
    assign sel_data  = ch_data[next_addr_q*DATA_W +: DATA_W];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sclk_sr   <= '1;
            csn_sr    <= '1;
            saddr_sr  <= '0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csn_rise  <= 1'b0;
            csn_fall  <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-1:0], adc_sclk};
            csn_sr    <= {csn_sr[SYNC_STAGES-1:0], adc_csn};
            saddr_sr  <= {saddr_sr[SYNC_STAGES-2:0], adc_saddr};
            sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
            sclk_fall <= ~sclk_sr[SYNC_STAGES-1] & sclk_sr[SYNC_STAGES];
            csn_rise  <= csn_sr[SYNC_STAGES-1] & ~csn_sr[SYNC_STAGES];
            csn_fall  <= ~csn_sr[SYNC_STAGES-1] & csn_sr[SYNC_STAGES];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            addr_sr_q   <= '0;
            next_addr_q <= '0;
            cur_addr    <= '0;
            last_data   <= '0;
            adc_sdat_oe <= 1'b0;
            frame_done  <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_sr_q   <= addr_sr_d;
            next_addr_q <= next_addr_d;
            cur_addr    <= cur_addr_d;
            last_data   <= last_data_d;
            adc_sdat_oe <= oe_d;
            frame_done  <= frame_done_d;
            wrapped_q   <= wrapped_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        addr_sr_d    = addr_sr_q;
        next_addr_d  = next_addr_q;
        cur_addr_d   = cur_addr;
        last_data_d  = last_data;
        oe_d         = adc_sdat_oe;
        frame_done_d = 1'b0;
        wrapped_d    = wrapped_q;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (csn_fall) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_d   = IDLE;
                    oe_d      = 1'b0;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    wrapped_d = 1'b0;
                end else if (sclk_fall) begin
                    // The first fall of a frame keeps the MSB presented since the load.
                    if (bit_cnt_q != '0)
                        shreg_d = shreg_q << 1;
                    else if (wrapped_q)
                        load = 1'b1;
                end else if (sclk_rise) begin
                    if (bit_cnt_q == CNT_W'(FRAME_W-1)) begin
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        wrapped_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (bit_cnt_q == CNT_W'(2) || bit_cnt_q == CNT_W'(3))
                        addr_sr_d = {addr_sr_q[0], saddr_bit};
                    if (bit_cnt_q == CNT_W'(4))
                        next_addr_d = {addr_sr_q, saddr_bit};
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cur_addr_d  = next_addr_q;
            last_data_d = sel_data;
            shreg_d     = {{LEAD_ZEROS{1'b0}}, sel_data};
            bit_cnt_d   = '0;
            oe_d        = 1'b1;
            wrapped_d   = 1'b0;
        end
    end
endmodule

// File: tb/tb_adc128s022_slave_model.sv
// tb/tb_adc128s022_slave_model.sv - scoreboard bench for adc128s022_slave_model
module tb_adc128s022_slave_model;
    localparam int S  = 2;
    localparam int DW = 12;
    localparam int H  = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic adc_sclk = 1'b1;
    logic adc_csn = 1'b1;
    logic adc_saddr = 1'b0;
    logic [DW-1:0] ch[8];
    logic [8*DW-1:0] ch_data;
    logic adc_sdat, adc_sdat_oe, frame_done;
    logic [2:0] cur_addr;
    logic [DW-1:0] last_data;

    adc128s022_slave_model #(.SYNC_STAGES(S), .DATA_W(DW), .LEAD_ZEROS(4)) dut (
        .CLK(CLK), .RST(RST), .adc_sclk(adc_sclk), .adc_csn(adc_csn), .adc_saddr(adc_saddr),
        .ch_data(ch_data), .adc_sdat(adc_sdat), .adc_sdat_oe(adc_sdat_oe),
        .cur_addr(cur_addr), .frame_done(frame_done), .last_data(last_data)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < 8; i++) ch_data[i*DW +: DW] = ch[i];
    end

    typedef struct {
        logic [15:0] word;
        logic [2:0]  addr;
        logic [11:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;
    logic [15:0] cap = '0;
    logic [2:0] m_next = '0;
    logic [2:0] plan[3];
    logic [1:0] fill_mode = 2'd0;
    int chg_rise = 0;
    logic [11:0] chg_val = '0;
    int rst_rise = 0;

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Master side: capture DOUT on each rising SCLK while selected.
    always @(posedge adc_sclk) if (!adc_csn) cap <= {cap[14:0], adc_sdat};

    always @(negedge CLK) begin
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_word", {16'd0, cap}, {16'd0, mon_e.word});
                check("cur_addr", {29'd0, cur_addr}, {29'd0, mon_e.addr});
                check("last_data", {20'd0, last_data}, {20'd0, mon_e.data});
            end
        end
    end

    task automatic burst(input int nfr, input int last_rises);
        logic [15:0] din;
        logic [2:0] a;
        int rises;
        int n;
        adc_csn = 1'b0;
        clks(H);
        for (int f = 0; f < nfr; f++) begin
            a = m_next;
            rises = (f != nfr-1) ? 16 : ((rst_rise > 0) ? rst_rise : last_rises);
            case (fill_mode)
                2'd1:    din = 16'($urandom);
                2'd2:    din = 16'hFFFF;
                default: din = 16'h0000;
            endcase
            din[13:11] = plan[f];
            if (rises == 16) exp_q.push_back('{word: {4'b0, ch[a]}, addr: a, data: ch[a]});
            for (int k = 1; k <= rises; k++) begin
                adc_sclk = 1'b0;
                adc_saddr = din[16-k];
                clks(H);
                adc_sclk = 1'b1;
                clks(H);
                if (k == chg_rise) ch[0] = chg_val;
            end
            if (rises >= 5) m_next = plan[f];
        end
        if (rst_rise > 0) begin
            RST = 1'b0;
            clks(2);
            check("rst_oe", {31'd0, adc_sdat_oe}, 32'd0);
            check("rst_sdat", {31'd0, adc_sdat}, 32'd0);
            check("rst_cur_addr", {29'd0, cur_addr}, 32'd0);
            adc_csn = 1'b1;
            adc_sclk = 1'b1;
            clks(2);
            RST = 1'b1;
            clks(2*H);
            m_next = '0;
            rst_rise = 0;
        end else begin
            adc_csn = 1'b1;
            n = 0;
            while (adc_sdat_oe && n < S+2) begin
                clks(1);
                n++;
            end
            check("oe_drop", {31'd0, adc_sdat_oe}, 32'd0);
            clks(2*H);
        end
        chg_rise = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ch[i] = 12'(i * 12'h111);
        plan[0] = 0; plan[1] = 0; plan[2] = 0;

        // Reset held while the master is active.
        RST = 1'b0;
        adc_csn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_sclk = ~adc_sclk;
            clks(H);
        end
        check("reset_oe", {31'd0, adc_sdat_oe}, 32'd0);
        check("reset_sdat", {31'd0, adc_sdat}, 32'd0);
        check("reset_cur_addr", {29'd0, cur_addr}, 32'd0);
        check("reset_last_data", {20'd0, last_data}, 32'd0);
        adc_csn = 1'b1;
        adc_sclk = 1'b1;
        clks(2);
        RST = 1'b1;
        clks(10);

        // Single frame from ch0.
        ch[0] = 12'hABC;
        fill_mode = 2'd0;
        burst(1, 16);
        check("single_last_data", {20'd0, last_data}, 32'hABC);

        // Address applies from the following frame.
        ch[5] = 12'h123;
        plan[0] = 3'd5;
        burst(1, 16);
        plan[0] = 3'd0;
        burst(1, 16);

        // Back-to-back frames with csn held low.
        ch[7] = 12'hFFF;
        ch[2] = 12'h001;
        plan[0] = 3'd7; plan[1] = 3'd2; plan[2] = 3'd4;
        burst(3, 16);

        // Abort after three rising edges with DIN high.
        fill_mode = 2'd2;
        plan[0] = 3'd7;
        burst(1, 3);
        fill_mode = 2'd0;
        plan[0] = 3'd0;
        burst(1, 16);

        // Mid-frame channel change, then reset mid-frame.
        ch[0] = 12'h555;
        chg_rise = 8;
        chg_val = 12'hAAA;
        burst(1, 16);
        plan[0] = 3'd6;
        rst_rise = 10;
        burst(1, 16);
        plan[0] = 3'd0;
        burst(1, 16);

        // Randomised traffic.
        fill_mode = 2'd1;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 8; i++) ch[i] = 12'($urandom);
            for (int i = 0; i < 3; i++) plan[i] = 3'($urandom);
            burst($urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16);
        end

        clks(20);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
